xif_mem_adapter: RTL and testbench
==================================

# xif_mem_adapter

Memory-side stage for the FPU coprocessor. It consumes the CORE-V-XIF memory request channel (`mem_valid`/`mem_ready`/`mem_req`/`mem_resp`) driven by the FPU model and converts each accepted request into a transaction on a simple grant/rvalid data bus. It returns load data to the FPU on the memory result channel (`mem_result_valid`/`mem_result`). Up to `MAX_OUTSTANDING` granted transactions are tracked in order by ID.

## Interface
Parameters:
- `X_ID_WIDTH`, 4 — width of XIF transaction ID.
- `XLEN`, 32 — address and data width.
- `MAX_OUTSTANDING`, 2 — depth of the outstanding-transaction FIFO; power of two, ≥1.

Ports (one clock `ck`; reset `rst` is asynchronous and active-low):
- `ck` in 1 — clock.
- `rst` in 1 — asynchronous reset, active low.
- `mem_valid` in 1 — XIF memory request valid.
- `mem_ready` out 1 — adapter can accept a request.
- `mem_req` in `x_mem_req_t` — id, addr, mode, we, size, be, attr, wdata, last, spec.
- `mem_resp` out `x_mem_resp_t` — exc, exccode, dbg; meaningful in the handshake cycle.
- `mem_result_valid` out 1 — load result valid; single-cycle pulse, no back-pressure.
- `mem_result` out `x_mem_result_t` — id, rdata, err, dbg.
- `data_req` out 1 — bus request.
- `data_gnt` in 1 — bus grant.
- `data_addr` out XLEN — byte address.
- `data_we` out 1 — write enable.
- `data_be` out 4 — byte enables.
- `data_wdata` out XLEN — write data.
- `data_rvalid` in 1 — bus response valid.
- `data_rdata` in XLEN — read data.
- `data_err` in 1 — bus error.
- `store_err` out 1 — one-cycle pulse when a store response carries `data_err`.

## Operation
- Handshake: a request is taken when `mem_valid && mem_ready`.
- `mem_ready` = `rst && !pending && !fifo_full`.
- Misalignment check, combinational in the handshake cycle:
  - misaligned means `size`==2 with `addr[1:0]`≠0, or `size`==1 with `addr[0]`≠0;
  - on misalignment: `mem_resp.exc`=1; `exccode`=6 for stores, 4 for loads;
  - no bus transaction and no `mem_result` follow.
- `mem_resp.dbg` is always 0.
- An aligned accepted request is latched into the request register (addr, we, be, wdata, id) and sets `pending`.
- FSM, two states:
  - IDLE → REQ on an aligned accept.
  - REQ drives `data_req`=1 with the latched fields held stable.
  - REQ → IDLE on `data_gnt`; at grant, {id, we} is pushed into the outstanding FIFO and `pending` clears.
- `data_rvalid` pops the FIFO head:
  - head is a load: next cycle `mem_result_valid`=1, `mem_result.id`=head id, `rdata`=`data_rdata`, `err`=`data_err`, `dbg`=0;
  - head is a store: no result; `store_err` pulses next cycle if `data_err`.
- `data_rvalid` with the FIFO empty is dropped and produces no output.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- The bus guarantees `data_rvalid` arrives ≥1 cycle after its `data_gnt`.

## Timing
- Reset state:
  - `data_req`, `mem_result_valid`, `store_err`, `mem_resp.*`, `data_*` registered outputs = 0;
  - FSM = IDLE; FIFO empty;
  - `mem_ready`=0 while `rst` is low, 1 in the first cycle after release.
- Accept in cycle N → `data_req`=1 in N+1.
- Grant in cycle G → `mem_ready` returns to 1 in G+1 if the FIFO is not full.
- Back-to-back throughput: one request per 2 cycles with zero-wait grant.
- `data_rvalid` in cycle R → `mem_result_valid` in R+1, exactly one cycle.
- FIFO full (`MAX_OUTSTANDING` granted, unanswered) → `mem_ready`=0 until a pop.
- Reset mid-operation clears `pending`, the FSM and the FIFO; bus responses arriving after reset are dropped.
- A request withdrawn before grant is not possible: the request register decouples XIF from the bus.

## Structure
- Constants go in `pa_rvfpm`:
  - `EXC_LD_MISALIGN`=4, `EXC_ST_MISALIGN`=6;
  - size encodings `SIZE_B`=0, `SIZE_H`=1, `SIZE_W`=2.
- XIF struct types are used unchanged from `in_xif`.
- One sub-module: `rvfpm_sync_fifo` (parameterised width/depth; push, pop, full, empty, head), holding {id, we}.

## Test plan
- Aligned load id=3, addr=0x100; `gnt` same cycle as `data_req`; `rvalid` 2 cycles later with rdata=0x3F800000 → one `mem_result_valid` pulse with id=3, rdata=0x3F800000, err=0.
- Store id=5, addr=0x204, wdata=0x40490FDB; `rvalid` with `data_err`=1 → `data_we`=1, `data_be`=0xF, no `mem_result`, one `store_err` pulse.
- Load with `size`=2, addr=0x102 → `mem_resp.exc`=1, `exccode`=4, `data_req` never rises; store variant gives `exccode`=6.
- Two loads ids 1 and 2 granted, no `rvalid` (`MAX_OUTSTANDING`=2) → `mem_ready`=0. Then `rvalid` ×2 → results in order id 1, then id 2; `mem_ready`=1 after the first pop.
- `gnt` of id 7 in the same cycle as `rvalid` for id 6 → id 6 result emitted and FIFO occupancy stays 1. A spurious `rvalid` with the FIFO empty → no output.
- Assert `rst` low while in REQ with one outstanding → `data_req`=0 immediately; a later `rvalid` produces no result.

Source files
------------

// File: rtl/in_xif.sv
`default_nettype none
// +------------------------------------------------------------------+
// | in_xif : CORE-V-XIF memory channel struct types                  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package in_xif;

    localparam int unsigned XIF_ID_WIDTH = 4;
    localparam int unsigned XIF_XLEN     = 32;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [XIF_XLEN-1:0]     addr;
        logic [1:0]              mode;
        logic                    we;
        logic [2:0]              size;
        logic [XIF_XLEN/8-1:0]   be;
        logic [1:0]              attr;
        logic [XIF_XLEN-1:0]     wdata;
        logic                    last;
        logic                    spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [XIF_XLEN-1:0]     rdata;
        logic                    err;
        logic                    dbg;
    } x_mem_result_t;

endpackage
`default_nettype wire

// File: rtl/pa_rvfpm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pa_rvfpm : shared constants and FSM state type for the FPU model  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package pa_rvfpm;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } adapter_state_t;

endpackage
`default_nettype wire

// File: rtl/rvfpm_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rvfpm_sync_fifo : small synchronous FIFO with head look-ahead    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module rvfpm_sync_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Explicit wrap keeps the pointers valid for any depth, including 1.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == C_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/xif_mem_adapter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xif_mem_adapter : XIF memory channel to grant/rvalid bus bridge  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module xif_mem_adapter
    import pa_rvfpm::*;
    import in_xif::*;
#(
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  x_mem_req_t      mem_req,
    output x_mem_resp_t     mem_resp,
    output logic            mem_result_valid,
    output x_mem_result_t   mem_result,
    output logic            data_req,
    input  logic            data_gnt,
    output logic [XLEN-1:0] data_addr,
    output logic            data_we,
    output logic [3:0]      data_be,
    output logic [XLEN-1:0] data_wdata,
    input  logic            data_rvalid,
    input  logic [XLEN-1:0] data_rdata,
    input  logic            data_err,
    output logic            store_err
);

    adapter_state_t        r_state;
    adapter_state_t        w_state_nxt;

    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic [3:0]            r_be;
    logic                  r_we;
    logic [X_ID_WIDTH-1:0] r_id;

    logic                  r_result_valid;
    logic                  r_store_err;
    x_mem_result_t         r_result;

    logic                  w_misaligned;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_pending;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [X_ID_WIDTH:0]   w_head;
    logic                  w_unused;

    assign w_misaligned = ((mem_req.size == SIZE_W) && (mem_req.addr[1:0] != 2'b00)) ||
                          ((mem_req.size == SIZE_H) && mem_req.addr[0]);
    assign w_pending    = (r_state == S_REQ);
    assign mem_ready    = rst && !w_pending && !w_fifo_full;
    assign w_accept     = mem_valid && mem_ready;
    assign w_take       = w_accept && !w_misaligned;
    assign w_pop        = data_rvalid && !w_fifo_empty;

    always_comb begin
        mem_resp = '0;
        if (w_accept && w_misaligned) begin
            mem_resp.exc     = 1'b1;
            mem_resp.exccode = mem_req.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        data_req    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                data_req = 1'b1;
                if (data_gnt) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request register: holds bus fields stable for the whole REQ phase.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_id    <= '0;
        end else if (w_take) begin
            r_addr  <= mem_req.addr;
            r_wdata <= mem_req.wdata;
            r_be    <= mem_req.be;
            r_we    <= mem_req.we;
            r_id    <= mem_req.id;
        end
    end

    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign data_be    = r_be;
    assign data_we    = r_we;

    rvfpm_sync_fifo #(
        .WIDTH (X_ID_WIDTH + 1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_outstanding (
        .ck    (ck),
        .rst   (rst),
        .push  (w_push),
        .din   ({r_id, r_we}),
        .pop   (w_pop),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_head)
    );

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_result_valid <= 1'b0;
            r_store_err    <= 1'b0;
            r_result       <= '0;
        end else begin
            r_result_valid <= w_pop && !w_head[0];
            r_store_err    <= w_pop && w_head[0] && data_err;
            if (w_pop && !w_head[0]) begin
                r_result.id    <= w_head[X_ID_WIDTH:1];
                r_result.rdata <= data_rdata;
                r_result.err   <= data_err;
                r_result.dbg   <= 1'b0;
            end
        end
    end

    assign mem_result_valid = r_result_valid;
    assign mem_result       = r_result;
    assign store_err        = r_store_err;

    assign w_unused = &{1'b0, mem_req.mode, mem_req.attr, mem_req.last, mem_req.spec};

endmodule
`default_nettype wire

// File: tb/tb_xif_mem_adapter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_xif_mem_adapter : directed self-checking bench                |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_xif_mem_adapter;
    import in_xif::*;

    logic          ck = 1'b0;
    logic          rst;
    logic          mem_valid;
    logic          mem_ready;
    x_mem_req_t    mem_req;
    x_mem_resp_t   mem_resp;
    logic          mem_result_valid;
    x_mem_result_t mem_result;
    logic          data_req;
    logic          data_gnt;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;
    logic          data_rvalid;
    logic [31:0]   data_rdata;
    logic          data_err;
    logic          store_err;

    int n_vec = 0;
    int n_err = 0;

    xif_mem_adapter #(
        .X_ID_WIDTH      (4),
        .XLEN            (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .ck               (ck),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_req          (mem_req),
        .mem_resp         (mem_resp),
        .mem_result_valid (mem_result_valid),
        .mem_result       (mem_result),
        .data_req         (data_req),
        .data_gnt         (data_gnt),
        .data_addr        (data_addr),
        .data_we          (data_we),
        .data_be          (data_be),
        .data_wdata       (data_wdata),
        .data_rvalid      (data_rvalid),
        .data_rdata       (data_rdata),
        .data_err         (data_err),
        .store_err        (store_err)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic set_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [2:0] size, input logic [31:0] wdata);
        mem_req       = '0;
        mem_req.id    = id;
        mem_req.addr  = addr;
        mem_req.we    = we;
        mem_req.size  = size;
        mem_req.be    = 4'hF;
        mem_req.wdata = wdata;
        mem_valid     = 1'b1;
        #1;
    endtask

    task automatic issue_granted(input logic [3:0] id, input logic [31:0] addr, input logic we);
        set_req(id, addr, we, 3'd2, 32'h0);
        tick();
        mem_valid = 1'b0;
        data_gnt  = 1'b1;
        tick();
        data_gnt  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        data_rvalid = 1'b1;
        data_rdata  = rdata;
        data_err    = err;
        tick();
        data_rvalid = 1'b0;
        data_err    = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        mem_valid   = 1'b0;
        mem_req     = '0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = '0;
        data_err    = 1'b0;
        #2;
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_data_req", data_req, 1'b0);
        check("rst_result_valid", mem_result_valid, 1'b0);
        check("rst_store_err", store_err, 1'b0);
        check("rst_data_addr", data_addr, 32'h0);
        check("rst_resp_exc", mem_resp.exc, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_ready", mem_ready, 1'b1);

        set_req(4'd3, 32'h100, 1'b0, 3'd2, 32'h0);
        check("ld_resp_exc", mem_resp.exc, 1'b0);
        tick();
        mem_valid = 1'b0;
        #1;
        check("ld_data_req", data_req, 1'b1);
        check("ld_data_addr", data_addr, 32'h100);
        check("ld_data_we", data_we, 1'b0);
        check("ld_busy_ready", mem_ready, 1'b0);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        #1;
        check("ld_gnt_req_drop", data_req, 1'b0);
        check("ld_gnt_ready", mem_ready, 1'b1);
        tick();
        check("ld_no_early_res", mem_result_valid, 1'b0);
        respond(32'h3F800000, 1'b0);
        check("ld_res_valid", mem_result_valid, 1'b1);
        check("ld_res_id", mem_result.id, 4'd3);
        check("ld_res_rdata", mem_result.rdata, 32'h3F800000);
        check("ld_res_err", mem_result.err, 1'b0);
        check("ld_res_dbg", mem_result.dbg, 1'b0);
        tick();
        check("ld_res_pulse", mem_result_valid, 1'b0);

        set_req(4'd5, 32'h204, 1'b1, 3'd2, 32'h40490FDB);
        tick();
        mem_valid = 1'b0;
        #1;
        check("st_data_we", data_we, 1'b1);
        check("st_data_be", data_be, 4'hF);
        check("st_data_addr", data_addr, 32'h204);
        check("st_data_wdata", data_wdata, 32'h40490FDB);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        respond(32'h0, 1'b1);
        check("st_store_err", store_err, 1'b1);
        check("st_no_result", mem_result_valid, 1'b0);
        tick();
        check("st_err_pulse", store_err, 1'b0);

        set_req(4'd1, 32'h102, 1'b0, 3'd2, 32'h0);
        check("mis_ld_exc", mem_resp.exc, 1'b1);
        check("mis_ld_code", mem_resp.exccode, 6'd4);
        check("mis_ld_dbg", mem_resp.dbg, 1'b0);
        tick();
        mem_valid = 1'b0;
        #1;
        check("mis_ld_no_req", data_req, 1'b0);
        check("mis_ld_ready", mem_ready, 1'b1);
        set_req(4'd1, 32'h102, 1'b1, 3'd2, 32'h0);
        check("mis_st_code", mem_resp.exccode, 6'd6);
        tick();
        mem_valid = 1'b0;
        #1;
        check("mis_st_no_req", data_req, 1'b0);
        set_req(4'd1, 32'h101, 1'b0, 3'd1, 32'h0);
        check("mis_half_exc", mem_resp.exc, 1'b1);
        mem_req.addr = 32'h102;
        #1;
        check("half_aligned_exc", mem_resp.exc, 1'b0);
        mem_req.addr = 32'h103;
        mem_req.size = 3'd0;
        #1;
        check("byte_exc", mem_resp.exc, 1'b0);
        mem_valid = 1'b0;
        #1;
        check("idle_resp_exc", mem_resp.exc, 1'b0);
        tick();
        check("no_accept_req", data_req, 1'b0);

        issue_granted(4'd1, 32'h300, 1'b0);
        check("one_out_ready", mem_ready, 1'b1);
        issue_granted(4'd2, 32'h304, 1'b0);
        check("full_ready", mem_ready, 1'b0);
        tick();
        check("full_ready_hold", mem_ready, 1'b0);
        respond(32'h11, 1'b0);
        check("ord1_valid", mem_result_valid, 1'b1);
        check("ord1_id", mem_result.id, 4'd1);
        check("ord1_rdata", mem_result.rdata, 32'h11);
        check("ord1_ready", mem_ready, 1'b1);
        respond(32'h22, 1'b1);
        check("ord2_valid", mem_result_valid, 1'b1);
        check("ord2_id", mem_result.id, 4'd2);
        check("ord2_rdata", mem_result.rdata, 32'h22);
        check("ord2_err", mem_result.err, 1'b1);

        issue_granted(4'd6, 32'h400, 1'b0);
        set_req(4'd7, 32'h404, 1'b0, 3'd2, 32'h0);
        tick();
        mem_valid = 1'b0;
        data_gnt  = 1'b1;
        respond(32'h66, 1'b0);
        data_gnt  = 1'b0;
        check("same_valid", mem_result_valid, 1'b1);
        check("same_id", mem_result.id, 4'd6);
        check("same_rdata", mem_result.rdata, 32'h66);
        check("same_ready", mem_ready, 1'b1);
        respond(32'h77, 1'b0);
        check("same_next_id", mem_result.id, 4'd7);
        check("same_next_valid", mem_result_valid, 1'b1);
        respond(32'hDEAD, 1'b1);
        check("spurious_result", mem_result_valid, 1'b0);
        check("spurious_st_err", store_err, 1'b0);

        issue_granted(4'd9, 32'h500, 1'b0);
        set_req(4'd10, 32'h504, 1'b0, 3'd2, 32'h0);
        tick();
        mem_valid = 1'b0;
        #1;
        check("pre_rst_req", data_req, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", data_req, 1'b0);
        check("mid_rst_ready", mem_ready, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("after_rst_ready", mem_ready, 1'b1);
        respond(32'h99, 1'b0);
        check("after_rst_drop", mem_result_valid, 1'b0);
        issue_granted(4'd12, 32'h600, 1'b0);
        respond(32'hABCD, 1'b0);
        check("fresh_id", mem_result.id, 4'd12);
        check("fresh_rdata", mem_result.rdata, 32'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
